// File: rtl/button_event_sequencer.sv
// Avalon-MM master servicing a button PIO: programs irq mask, reads/clears edge capture, queues events.
// Optional BTN_SEQ_TIMESTAMP_EN adds a free-running timestamp stored with each event.
//
// state | meaning
// INIT  | write MASK_INIT to irq_mask (addr 2) once reset has been released
// IDLE  | wait for PIO irq
// RD    | present edge-capture read (addr 3)
// WAIT  | readdata valid; latch capture, skip spurious zero reads
// CLR   | write back exactly the captured bits to clear them
// PUSH  | queue the capture, or drop it and flag overflow when full
module button_event_sequencer #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] MASK_INIT  = 4'hF,
  parameter int unsigned      TS_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic [31:0]         m_readdata,
  input  logic                m_irq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [WIDTH-1:0]    evt_data,
`ifdef BTN_SEQ_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] evt_ts,
`endif
  output logic                evt_overflow,
  input  logic                ovf_clear
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WAIT, S_CLR, S_PUSH} state_t;

  state_t           state, next_state;
  logic             armed;
  logic [WIDTH-1:0] cap;
  logic             push_req;

  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, do_push, do_pop;

  logic unused_rd;
  assign unused_rd = ^m_readdata[31:WIDTH];

  // armed holds INIT for one cycle after reset release so the mask write is visible
  // outside reset while all bus outputs read idle during reset itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      armed <= 1'b0;
      cap   <= '0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (state == S_WAIT) cap <= m_readdata[WIDTH-1:0];
    end
  end

  always_comb begin
    next_state   = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 2'd0;
    m_writedata  = 32'd0;
    push_req     = 1'b0;
    case (state)
      S_INIT: begin
        if (armed) begin
          m_chipselect = 1'b1;
          m_write_n    = 1'b0;
          m_address    = 2'd2;
          m_writedata  = {{(32-WIDTH){1'b0}}, MASK_INIT};
          next_state   = S_IDLE;
        end
      end
      S_IDLE: if (m_irq) next_state = S_RD;
      S_RD: begin
        m_chipselect = 1'b1;
        m_address    = 2'd3;
        next_state   = S_WAIT;
      end
      S_WAIT: next_state = (m_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR;
      S_CLR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 2'd3;
        m_writedata  = {{(32-WIDTH){1'b0}}, cap};
        next_state   = S_PUSH;
      end
      S_PUSH: begin
        push_req   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_INIT;
    endcase
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign do_push   = push_req & ~full;
  assign do_pop    = evt_valid & evt_ready;
  assign evt_data  = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= cap;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 evt_overflow <= 1'b0;
    else if (push_req && full)    evt_overflow <= 1'b1;
    else if (ovf_clear)           evt_overflow <= 1'b0;
  end

`ifdef BTN_SEQ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt, ts_cap;
  logic [TS_WIDTH-1:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_cap <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == S_WAIT) ts_cap <= ts_cnt;
      if (do_push) mem_ts[wr_ptr] <= ts_cap;
    end
  end

  assign evt_ts = mem_ts[rd_ptr];
`else
  logic [TS_WIDTH-1:0] unused_ts;
  assign unused_ts = '0;
`endif

endmodule
